// File: rtl/pipe_pkg.sv
// Shared types and sizing for the pipeline hazard/flow controller.
package pipe_pkg;
    localparam int REG_W = 5;
    localparam int NREG  = 32;
    localparam int CNT_W = 2;
    localparam logic [5:0] OP_HALT = 6'b010001;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } pipe_state_t;
endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register pending-write counters (r1..r31); r0 is hardwired idle.
module pipe_scoreboard
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic [REG_W-1:0] inc_dest,
    input  logic             dec_en,
    input  logic [REG_W-1:0] dec_dest,
    output logic [NREG-1:0]  busy,
    output logic             all_clear
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign busy[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic [CNT_W-1:0] cnt;
        logic             inc_hit;
        logic             dec_hit;

        assign inc_hit = inc_en && (inc_dest == REG_W'(i));
        assign dec_hit = dec_en && (dec_dest == REG_W'(i));

        // A same-cycle issue and writeback of one register cancel out.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (inc_hit && !dec_hit) begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            end else if (dec_hit && !inc_hit) begin
                if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
        end

        assign busy[i] = (cnt != '0);
    end

    assign all_clear = (busy == '0);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline flow controller: RAW stall, branch flush and HALT drain sequencing.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
//
// state   | meaning
// RUN     | normal issue; stall on RAW hazard
// BR_WAIT | branch issued, fetch held and IF/ID flushed until EX resolves it
// DRAIN   | HALT issued, waiting for all pending writes to retire
// HALTED  | pipeline drained, frozen until reset
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_is_branch,
    input  logic             id_is_halt,
    input  logic             wb_valid,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             ex_br_valid,
    input  logic             ex_br_taken,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);
    pipe_state_t     state;
    pipe_state_t     state_nxt;
    logic [NREG-1:0] busy;
    logic            all_clear;
    logic            hazard;
    logic            issue;

    assign hazard = id_valid && (((id_rs != '0) && busy[id_rs]) ||
                                 ((id_rt != '0) && busy[id_rt]));
    assign issue  = id_valid && !hazard && (state == RUN) && !rst;

    pipe_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (issue && id_reg_write),
        .inc_dest  (id_dest),
        .dec_en    (wb_valid && wb_reg_write),
        .dec_dest  (wb_dest),
        .busy      (busy),
        .all_clear (all_clear)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;
        if (rst) begin
            ifid_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                        // Branch wins when both decode flags are set.
                        if (issue && id_is_branch)    state_nxt = BR_WAIT;
                        else if (issue && id_is_halt) state_nxt = DRAIN;
                    end
                end
                BR_WAIT: begin
                    if (ex_br_valid) begin
                        pc_en      = 1'b1;
                        pc_sel     = ex_br_taken;
                        ifid_flush = ex_br_taken;
                        state_nxt  = RUN;
                    end else begin
                        ifid_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    ifid_flush = 1'b1;
                    if (all_clear) state_nxt = HALTED;
                end
                HALTED: begin
                    ifid_flush = 1'b1;
                    halted     = 1'b1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (idex_bubble) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (ifid_flush)  perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver queues expected outputs per cycle, monitor compares.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_reg_write, id_is_branch, id_is_halt;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       wb_valid, wb_reg_write;
    logic [4:0] wb_dest;
    logic       ex_br_valid, ex_br_taken;
    logic       pc_en, pc_sel, ifid_flush, idex_bubble, halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    typedef struct {
        logic [4:0] e;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // {pc_en, pc_sel, ifid_flush, idex_bubble, halted}
    localparam logic [4:0] E_RUN   = 5'b10000;
    localparam logic [4:0] E_STALL = 5'b00010;
    localparam logic [4:0] E_FLUSH = 5'b00100;
    localparam logic [4:0] E_RST   = 5'b00100;
    localparam logic [4:0] E_HALT  = 5'b00101;
    localparam logic [4:0] E_BR_T  = 5'b11100;
    localparam logic [4:0] E_BR_NT = 5'b10000;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_is_branch (id_is_branch),
        .id_is_halt   (id_is_halt),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_dest      (wb_dest),
        .ex_br_valid  (ex_br_valid),
        .ex_br_taken  (ex_br_taken),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .halted       (halted)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic drv_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dest, input logic rw, input logic br,
                          input logic [5:0] op);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_dest      = dest;
        id_reg_write = rw;
        id_is_branch = br;
        id_is_halt   = (op == OP_HALT);
    endtask

    task automatic drv_wb(input logic v, input logic [4:0] d);
        wb_valid     = v;
        wb_reg_write = v;
        wb_dest      = d;
    endtask

    task automatic drv_ex(input logic v, input logic t);
        ex_br_valid = v;
        ex_br_taken = t;
    endtask

    task automatic idle();
        drv_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
        drv_wb(1'b0, 5'd0);
        drv_ex(1'b0, 1'b0);
    endtask

    task automatic step(input logic [4:0] e, input string tag);
        exp_t x;
        x.e   = e;
        x.tag = tag;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [4:0] act;
            x   = exp_q.pop_front();
            act = {pc_en, pc_sel, ifid_flush, idex_bubble, halted};
            n_vec++;
            if (act !== x.e) begin
                n_bad++;
                $display("FAIL %s: got {pc_en,pc_sel,flush,bubble,halted}=%b expected %b @%0t",
                         x.tag, act, x.e, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        step(E_RST, "rst_idle");
        drv_id(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 6'd0);
        step(E_RST, "rst_with_id");
        idle();
        rst = 1'b0;

        // RAW on r5: stall until its writeback, then issue
        drv_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 6'd0); step(E_RUN, "wr_r5");
        drv_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 6'd0);
        step(E_STALL, "raw_r5_a");
        step(E_STALL, "raw_r5_b");
        drv_wb(1'b1, 5'd5); step(E_STALL, "raw_r5_wb");
        drv_wb(1'b0, 5'd0); step(E_RUN, "raw_r5_issue");
        idle(); drv_wb(1'b1, 5'd6); step(E_RUN, "wb_r6");

        // Same-cycle issue and WB of r7 keeps count at 1
        idle(); drv_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 6'd0); step(E_RUN, "wr_r7");
        drv_wb(1'b1, 5'd7); step(E_RUN, "wr_wb_r7");
        idle(); drv_id(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0); step(E_STALL, "r7_held");
        drv_wb(1'b1, 5'd7); step(E_STALL, "r7_wb");
        drv_wb(1'b0, 5'd0); step(E_RUN, "r7_free");

        // Saturation at 3 and no underflow below 0 (r9, read through rt)
        idle(); drv_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 6'd0);
        repeat (4) step(E_RUN, "wr_r9");
        drv_id(1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 6'd0); step(E_STALL, "r9_sat");
        drv_wb(1'b1, 5'd9);
        repeat (3) step(E_STALL, "r9_drain");
        drv_wb(1'b0, 5'd0); step(E_RUN, "r9_free");
        idle(); drv_wb(1'b1, 5'd9); step(E_RUN, "wb_r9_extra");
        idle(); drv_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 6'd0); step(E_RUN, "wr_r9_again");
        drv_id(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0); drv_wb(1'b1, 5'd9);
        step(E_STALL, "r9_no_underflow");
        drv_wb(1'b0, 5'd0); step(E_RUN, "r9_clear");

        // Branch taken after three wait cycles; ex_br_valid ignored in RUN
        idle(); drv_ex(1'b1, 1'b1); step(E_RUN, "ex_ignored_run");
        idle(); drv_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'd0); step(E_RUN, "br_issue");
        idle();
        repeat (3) step(E_FLUSH, "br_wait");
        drv_ex(1'b1, 1'b1); step(E_BR_T, "br_taken");
        idle(); step(E_RUN, "br_back_run");
        // Branch+halt together behaves as a branch (not-taken resolve)
        drv_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, OP_HALT); step(E_RUN, "br_halt_issue");
        idle(); step(E_FLUSH, "br_halt_wait");
        drv_ex(1'b1, 1'b0); step(E_BR_NT, "br_not_taken");
        idle(); step(E_RUN, "br_nt_run");

        // Reset in BR_WAIT
        drv_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 6'd0); step(E_RUN, "wr_r4");
        drv_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'd0); step(E_RUN, "br2_issue");
        idle(); step(E_FLUSH, "br2_wait");
        rst = 1'b1; step(E_RST, "rst_brwait"); rst = 1'b0;
        drv_ex(1'b1, 1'b1); step(E_RUN, "post_rst_run");
        idle(); drv_id(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0); step(E_RUN, "r4_cleared");

        // HALT with r3 pending: drain, then sticky halted
        idle(); drv_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 6'd0); step(E_RUN, "wr_r3");
        drv_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, OP_HALT); step(E_RUN, "halt_issue");
        idle();
        repeat (2) step(E_FLUSH, "drain");
        drv_wb(1'b1, 5'd3); step(E_FLUSH, "drain_wb_r3");
        idle(); step(E_FLUSH, "drain_clear");
        step(E_HALT, "halted");
        drv_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 6'd0); drv_ex(1'b1, 1'b1);
        repeat (3) step(E_HALT, "halted_sticky");
        idle(); rst = 1'b1; step(E_RST, "rst_halted"); rst = 1'b0;
        step(E_RUN, "run_after_halt");

        // Reset in DRAIN
        drv_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 6'd0); step(E_RUN, "wr_r3b");
        drv_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, OP_HALT); step(E_RUN, "halt2_issue");
        idle(); step(E_FLUSH, "drain2");
        rst = 1'b1; step(E_RST, "rst_drain"); rst = 1'b0;
        drv_id(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0); step(E_RUN, "r3_cleared");

        // 4 stall cycles and 2 flush cycles since the last reset
        idle(); drv_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 6'd0); step(E_RUN, "p_wr_r5");
        drv_id(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 6'd0);
        repeat (3) step(E_STALL, "p_stall");
        drv_wb(1'b1, 5'd5); step(E_STALL, "p_stall_wb");
        drv_wb(1'b0, 5'd0); step(E_RUN, "p_issue");
        idle(); drv_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'd0); step(E_RUN, "p_br");
        idle();
        repeat (2) step(E_FLUSH, "p_flush");
        drv_ex(1'b1, 1'b0); step(E_BR_NT, "p_nt");
        idle();
`ifdef PIPE_CTRL_PERF_EN
        n_vec++;
        if (perf_stall_cnt !== 32'd4) begin
            n_bad++;
            $display("FAIL perf_stall_cnt: got %0d expected 4", perf_stall_cnt);
        end
        n_vec++;
        if (perf_flush_cnt !== 32'd2) begin
            n_bad++;
            $display("FAIL perf_flush_cnt: got %0d expected 2", perf_flush_cnt);
        end
`endif

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
